mux_sel_scheduler: RTL and testbench
====================================

# mux_sel_scheduler

Round-robin scheduler that shares a 5-input source-select mux among five requesters. It grants one source at a time, drives the mux select code for a programmable dwell time, and samples the mux output `f` at the end of each completed dwell. It sits in front of the select-driven mux structure and replaces hand-driven select stimulus with a sequenced, arbitrated controller.

## Interface
Parameters:
- `N_SRC`, 5: number of requesters / mux inputs (legal 2..8)
- `SEL_W`, 3: select code width, must satisfy 2^SEL_W >= N_SRC
- `DWELL_W`, 4: dwell counter width

Ports:
- `clk`  in  1  rising-edge clock, the only clock
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  N_SRC  per-source request, level, held until served
- `dwell`  in  DWELL_W  hold length in cycles; 0 is treated as 1; sampled at grant
- `f_in`  in  1  mux output being scheduled
- `grant`  out  N_SRC  one-hot grant, registered, all-zero when no owner
- `sel`  out  SEL_W  binary index of current or last owner, registered
- `busy`  out  1  high while in HOLD
- `sample_vld`  out  1  one-cycle pulse at the end of a completed dwell
- `sample_data`  out  1  `f_in` captured at the completing edge
- `sample_src`  out  SEL_W  index of the source that produced `sample_data`

## Operation
- FSM states: IDLE, HOLD, GAP. Reset state is IDLE.
- IDLE or GAP, at an edge with any `req` bit high: pick the winner, set `grant` one-hot and `sel` to its index, load the counter with max(dwell,1)-1, and enter HOLD. GAP with no request moves to IDLE. IDLE with no request stays in IDLE.
- Winner selection is round-robin: search starts at `last+1` mod N_SRC, wrapping to 0. `last` updates at each grant. After reset `last` = N_SRC-1, so source 0 has first priority.
- HOLD: the counter decrements each edge.
  - Completing edge (counter==0 and the owner's `req` still high): clear `grant`, pulse `sample_vld` with `sample_data` = `f_in` and `sample_src` = `sel`, then enter GAP.
  - Early release (owner's `req` low at any HOLD edge, including the counter==0 edge): clear `grant`, no sample, enter GAP.
- `req` changes of non-owners during HOLD are ignored until the next arbitration.
- `sel` holds its value in IDLE and GAP. The mux never sees a spurious select change.
- `dwell` changes during HOLD have no effect on the current grant.
- `rst_n` low at any time (including mid-HOLD) forces IDLE immediately: `grant`=0, `sel`=0, `busy`=0, `sample_vld`=0, `sample_data`=0, `sample_src`=0, counter=0, `last`=N_SRC-1.

## Timing
- Grant latency: `req` high before edge k from IDLE gives `grant`/`sel` valid after edge k (1 cycle).
- A granted source owns the mux for exactly max(dwell,1) cycles. `busy` is high for those same cycles.
- GAP is always exactly 1 cycle with `grant`=0. It serves as the select-settle / turnaround bubble. Back-to-back service therefore has a period of max(dwell,1)+1 cycles.
- `sample_vld` is high during the GAP cycle only.
- Maximum wait for a continuously requesting source: (N_SRC-1)*(2^DWELL_W) cycles including gaps.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared header `mux_sched_defs.vh`: state encodings (IDLE=2'd0, HOLD=2'd1, GAP=2'd2), the default N_SRC/SEL_W/DWELL_W values, and the reset value of `last`.
- One combinational sub-module, `rr_pick`. Inputs: `req`, `last`. Outputs: `any`, `win_idx`, `win_onehot`. Implementation uses a double-width rotate and a priority encode.
- The top holds the FSM, dwell counter, `last` register and sample register.

## Test plan
- Reset/idle: `rst_n`=0 then 1, `req`=0 → all outputs 0, state IDLE, `sel`=0 held for 10 cycles.
- Single requester: `req`=5'b00100, `dwell`=3 → `grant`=00100 and `sel`=2 one cycle later, held 3 cycles. Then `sample_vld` pulses once with `sample_src`=2 and `sample_data`=`f_in` at that edge. The sequence repeats with period 4.
- Round-robin fairness: `req`=5'b11111, `dwell`=1 → grants 0,1,2,3,4,0 in order, each separated by one GAP cycle.
- Early release: grant source 1 with `dwell`=8, drop `req[1]` after 3 cycles → `grant` clears at that edge, no `sample_vld`. Source 3 (requesting) is granted after the 1-cycle GAP.
- Dwell edge cases: `dwell`=0 behaves as 1. `dwell`=15 gives a 15-cycle hold. Changing `dwell` mid-HOLD does not alter the current hold length.
- Reset mid-HOLD: assert `rst_n`=0 during cycle 2 of a 5-cycle hold on source 4 → outputs go to 0 asynchronously. After release with `req`=5'b10001, source 0 is granted first.

Source files
------------

// File: rtl/mux_sel_scheduler_pkg.sv
// Shared types and defaults for the round-robin mux select scheduler.
package mux_sel_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int DEF_N_SRC   = 5;
  localparam int DEF_SEL_W   = 3;
  localparam int DEF_DWELL_W = 4;

  // Last-owner reset value: the top index, so source 0 wins the first arbitration.
  function automatic int last_rst(input int n_src);
    return n_src - 1;
  endfunction

endpackage

// File: rtl/mux_sel_scheduler_if.sv
// Requester / mux-facing bundle of the scheduler; master drives requests, slave is the scheduler.
interface mux_sel_scheduler_if #(
  parameter int N_SRC   = mux_sel_scheduler_pkg::DEF_N_SRC,
  parameter int SEL_W   = mux_sel_scheduler_pkg::DEF_SEL_W,
  parameter int DWELL_W = mux_sel_scheduler_pkg::DEF_DWELL_W
);
  logic [N_SRC-1:0]   req;
  logic [DWELL_W-1:0] dwell;
  logic               f_in;
  logic [N_SRC-1:0]   grant;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic               sample_vld;
  logic               sample_data;
  logic [SEL_W-1:0]   sample_src;

  modport master (
    output req, dwell, f_in,
    input  grant, sel, busy, sample_vld, sample_data, sample_src
  );

  modport slave (
    input  req, dwell, f_in,
    output grant, sel, busy, sample_vld, sample_data, sample_src
  );
endinterface

// File: rtl/mux_sel_scheduler_rr_pick.sv
// Combinational round-robin picker: rotate requests to start after the last owner,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int N_SRC = 5,
  parameter int SEL_W = 3
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] win_idx,
  output logic [N_SRC-1:0] win_onehot
);
  localparam int IW = $clog2(2 * N_SRC);

  logic [SEL_W-1:0]   start;
  logic [2*N_SRC-1:0] req_dbl;
  logic [N_SRC-1:0]   rot;
  logic [SEL_W-1:0]   off;
  logic [SEL_W:0]     sum;

  assign start   = (last >= SEL_W'(N_SRC - 1)) ? '0 : last + SEL_W'(1);
  assign req_dbl = {req, req};
  assign any     = |req;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      rot[i] = req_dbl[IW'(start) + IW'(i)];
    end
  end

  // Descending scan so the lowest set bit of the rotated vector wins.
  always_comb begin
    off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign sum        = {1'b0, start} + {1'b0, off};
  assign win_idx    = (sum >= (SEL_W+1)'(N_SRC)) ? SEL_W'(sum - (SEL_W+1)'(N_SRC))
                                                 : sum[SEL_W-1:0];
  assign win_onehot = any ? (N_SRC'(1) << win_idx) : '0;

endmodule

// File: rtl/mux_sel_scheduler.sv
// Arbitrates five requesters onto a shared mux select, holds each grant for a dwell
// window, and captures the mux output at the end of every completed window.
module mux_sel_scheduler
  import mux_sel_scheduler_pkg::*;
#(
  parameter int N_SRC   = DEF_N_SRC,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_scheduler_if.slave bus
);
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(last_rst(N_SRC));

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               busy_q, busy_d;
  logic               sample_vld_q, sample_vld_d;
  logic               sample_data_q, sample_data_d;
  logic [SEL_W-1:0]   sample_src_q, sample_src_d;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic [N_SRC-1:0]   pick_onehot;
  logic               owner_req;
  logic [DWELL_W-1:0] cnt_load;

  rr_pick #(.N_SRC(N_SRC), .SEL_W(SEL_W)) u_pick (
    .req        (bus.req),
    .last       (last_q),
    .any        (pick_any),
    .win_idx    (pick_idx),
    .win_onehot (pick_onehot)
  );

  assign owner_req = |(bus.req & grant_q);
  assign cnt_load  = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    grant_d       = grant_q;
    sel_d         = sel_q;
    sample_vld_d  = 1'b0;
    sample_data_d = sample_data_q;
    sample_src_d  = sample_src_q;
    case (state_q)
      ST_HOLD: begin
        if (!owner_req) begin
          grant_d = '0;
          state_d = ST_GAP;
        end else if (cnt_q == '0) begin
          grant_d       = '0;
          sample_vld_d  = 1'b1;
          sample_data_d = bus.f_in;
          sample_src_d  = sel_q;
          state_d       = ST_GAP;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      // IDLE and GAP arbitrate identically; sel is left alone unless a new grant lands.
      default: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          sel_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = cnt_load;
          state_d = ST_HOLD;
        end else begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
    busy_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      last_q        <= LAST_RST;
      grant_q       <= '0;
      sel_q         <= '0;
      busy_q        <= 1'b0;
      sample_vld_q  <= 1'b0;
      sample_data_q <= 1'b0;
      sample_src_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      sel_q         <= sel_d;
      busy_q        <= busy_d;
      sample_vld_q  <= sample_vld_d;
      sample_data_q <= sample_data_d;
      sample_src_q  <= sample_src_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.sel         = sel_q;
  assign bus.busy        = busy_q;
  assign bus.sample_vld  = sample_vld_q;
  assign bus.sample_data = sample_data_q;
  assign bus.sample_src  = sample_src_q;

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Scoreboard bench: each scenario queues the grants it expects; a negedge monitor
// pops them as grants appear and checks owner, hold length, gap and sample.
module tb_mux_sel_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic f_edge = 1'b0;

  mux_sel_scheduler_if bus ();

  mux_sel_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int src;
    int len;
    bit smp;
    bit b2b;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;
  int   n_done = 0;
  int   hold_cnt = 0;
  int   idle_cnt = 0;
  logic [4:0] prev_g = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input int s, input int l, input bit smp, input bit b2b);
    exp_t e;
    e.src = s; e.len = l; e.smp = smp; e.b2b = b2b;
    expq.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // f_in is captured at each rising edge before it is re-randomised.
  always @(posedge clk) begin
    f_edge = bus.f_in;
    #1 bus.f_in = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_g   = '0;
      hold_cnt = 0;
      idle_cnt = 0;
    end else begin
      if (bus.grant != '0 && prev_g == '0) begin
        if (expq.size() == 0) begin
          chk("unexpected_grant", 32'(bus.grant), 32'd0);
          cur.src = 0; cur.len = 0; cur.smp = 1'b0; cur.b2b = 1'b0;
        end else begin
          cur = expq.pop_front();
          chk("grant", 32'(bus.grant), 32'(1 << cur.src));
          chk("sel", 32'(bus.sel), 32'(cur.src));
          if (cur.b2b) chk("gap_len", 32'(idle_cnt), 32'd1);
        end
        hold_cnt = 1;
      end else if (bus.grant != '0) begin
        chk("hold_grant", 32'(bus.grant), 32'(1 << cur.src));
        hold_cnt++;
      end else if (prev_g != '0) begin
        chk("hold_len", 32'(hold_cnt), 32'(cur.len));
        chk("sample_vld", 32'(bus.sample_vld), 32'(cur.smp));
        chk("sel_hold", 32'(bus.sel), 32'(cur.src));
        if (cur.smp) begin
          chk("sample_src", 32'(bus.sample_src), 32'(cur.src));
          chk("sample_data", 32'(bus.sample_data), 32'(f_edge));
        end
        hold_cnt = 0;
        idle_cnt = 1;
        n_done++;
      end else begin
        idle_cnt++;
        if (bus.sample_vld) chk("spurious_vld", 32'(bus.sample_vld), 32'd0);
      end
      chk("busy", 32'(bus.busy), 32'(bus.grant != '0));
      prev_g = bus.grant;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.dwell = '0;
    repeat (3) step();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_sample_src", 32'(bus.sample_src), 32'd0);
    rst_n = 1'b1;

    // idle after reset: nothing moves for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_grant", 32'(bus.grant), 32'd0);
      chk("idle_sel", 32'(bus.sel), 32'd0);
      chk("idle_vld", 32'(bus.sample_vld), 32'd0);
    end

    // single requester, dwell 3, period 4
    bus.dwell = 4'd3;
    push(2, 3, 1, 0); push(2, 3, 1, 1); push(2, 3, 1, 1);
    base = n_done;
    bus.req = 5'b00100;
    @(negedge clk); #1;
    chk("lat_grant", 32'(bus.grant), 32'h04);
    chk("lat_sel", 32'(bus.sel), 32'd2);
    wait (n_done == base + 3);
    bus.req = '0;
    repeat (4) step();

    // round robin, all requesting, dwell 1
    do_reset();
    bus.dwell = 4'd1;
    push(0, 1, 1, 0);
    for (int s = 1; s < 5; s++) push(s, 1, 1, 1);
    push(0, 1, 1, 1);
    base = n_done;
    bus.req = 5'b11111;
    wait (n_done == base + 6);
    bus.req = '0;
    repeat (4) step();

    // early release of source 1 after 3 cycles; source 3 follows after one gap
    do_reset();
    bus.dwell = 4'd8;
    push(1, 3, 0, 0); push(3, 8, 1, 1);
    base = n_done;
    bus.req = 5'b01010;
    wait (hold_cnt == 3);
    bus.req = 5'b01000;
    wait (n_done == base + 2);
    bus.req = '0;
    repeat (4) step();

    // dwell 0 acts as 1
    do_reset();
    bus.dwell = 4'd0;
    push(0, 1, 1, 0);
    base = n_done;
    bus.req = 5'b00001;
    wait (n_done == base + 1);
    bus.req = '0;
    repeat (3) step();

    // dwell 15
    bus.dwell = 4'd15;
    push(1, 15, 1, 0);
    base = n_done;
    bus.req = 5'b00010;
    wait (n_done == base + 1);
    bus.req = '0;
    repeat (3) step();

    // dwell changed mid-hold keeps the length latched at grant
    bus.dwell = 4'd5;
    push(2, 5, 1, 0);
    base = n_done;
    bus.req = 5'b00100;
    wait (hold_cnt == 2);
    bus.dwell = 4'd9;
    wait (n_done == base + 1);
    bus.req = '0;
    repeat (3) step();

    // reset in cycle 2 of a 5-cycle hold on source 4
    do_reset();
    bus.dwell = 4'd5;
    push(4, 5, 1, 0);
    bus.req = 5'b10000;
    wait (hold_cnt == 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(bus.grant), 32'd0);
    chk("arst_sel", 32'(bus.sel), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_vld", 32'(bus.sample_vld), 32'd0);
    chk("arst_data", 32'(bus.sample_data), 32'd0);
    bus.req   = 5'b10001;
    bus.dwell = 4'd2;
    push(0, 2, 1, 0); push(4, 2, 1, 1);
    base = n_done;
    repeat (2) step();
    rst_n = 1'b1;
    wait (n_done == base + 2);
    bus.req = '0;
    repeat (5) step();

    chk("queue_left", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
